sprite_cmd_scheduler: RTL and testbench
=======================================

Name: sprite_cmd_scheduler

Overview:
- Sits between the HPS register bus and the single-port sprite descriptor table inside the top level.
- HPS writes six staging bytes, then a commit write that carries the sprite index. Each commit queues one 48-bit descriptor write.
- The block drains the queue into the table, sharing the table port with the renderer. The renderer always has priority.
- Table writes happen only inside the blanking window unless the HPS requests a flush.

Parameters:
- DEPTH, 8: command FIFO entries, a power of two ≥2.
- IDX_W, 8: table index width.
- VBLANK_GATE, 1: 1 = drain only while vblank=1; 0 = drain on any idle cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low; 0 = reset on the next rising clk
- hps_writedata  in  8  bus write data
- hps_address  in  3  register select
- hps_write  in  1  write strobe; qualified by hps_chipselect
- hps_read  in  1  read strobe; qualified by hps_chipselect
- hps_chipselect  in  1  block select
- hps_readdata  out  8  status readback, registered
- vblank  in  1  renderer blanking window
- rnd_req  in  1  renderer table read request
- rnd_addr  in  IDX_W  renderer read index
- rnd_gnt  out  1  renderer owns the table port this cycle
- tbl_addr  out  IDX_W  table address
- tbl_we  out  1  table write enable
- tbl_wdata  out  48  table write data
- flush_done  out  1  one-cycle pulse when a flush completes

Behaviour:
- Reset (reset=0 at a clk edge) clears:
  - all staging bytes and the FIFO (count=0);
  - the overflow flag, hps_readdata and flush_done;
  - the FSM, which goes to NORMAL.
- The table outputs are combinational, so while reset is held tbl_we=0.
- A bus write is accepted when hps_chipselect=1 and hps_write=1.
- Address 0–5: staging byte N ← hps_writedata. Byte 0 = descriptor bits [7:0], byte 5 = bits [47:40]. Staging keeps its value after a commit, so partial updates are allowed.
- Address 6 (commit): push {hps_writedata[IDX_W-1:0], staging[47:0]}.
  - The push sees staging writes made in earlier cycles only.
  - The push is accepted if count<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the command is dropped and overflow is set (sticky).
- Address 7 (control):
  - bit0=1: request a flush.
  - bit1=1: clear overflow. If a drop happens in the same cycle, set wins.
  - Other bits are ignored.
- Bus read with hps_chipselect=1 and hps_read=1: hps_readdata on the next cycle = {4'b0, state==FLUSH, overflow, fifo_empty, fifo_full}. The address is ignored.
- Drain window: win = (VBLANK_GATE==0) | vblank | (state==FLUSH).
- Arbitration, combinational:
  - rnd_gnt = rnd_req.
  - pop = !rnd_req & win & !empty.
  - tbl_we = pop.
  - tbl_addr = rnd_req ? rnd_addr : head.idx.
  - tbl_wdata = head.data. It is don't-care when tbl_we=0 but must be stable, never X, after reset.
- Each pop retires one entry, so peak throughput is one table write per clk. The earliest table write is the cycle after the commit write.
- FIFO: circular pointers with wrap at DEPTH. Order is strict FIFO, so two commits to the same index land in commit order.
- FSM:
  - NORMAL → FLUSH on a flush request. If the FIFO is empty at the request, it still enters FLUSH for one cycle.
  - FLUSH → NORMAL in the cycle after count reaches 0. flush_done=1 for exactly that one cycle.
  - Commits during FLUSH are accepted and extend the flush.
  - A flush request while already in FLUSH is ignored.
  - A renderer request still pre-empts writes during FLUSH.
- A mid-operation reset discards all queued commands; no partial table write is emitted.

Test Plan:
1. Stage bytes 0..5 = FD,FF,FF,FF,00,00, commit idx=0x05, hold vblank=0 for 20 clks, then raise vblank → tbl_we stays 0 until vblank rises. One tbl_we pulse follows, with tbl_addr=0x05 and tbl_wdata=48'h0000_FFFF_FFFD.
2. vblank=1, commit idx 0..7 back to back, then a 9th commit idx=0x08 in the same cycle as the first pop → all 9 written, in order. overflow=0 and readdata bit2=0.
3. vblank=0, commit 9 entries (DEPTH=8) → the 9th is dropped and readdata shows overflow=1, full=1. Write addr7=0x02 → overflow=0 on the next read.
4. vblank=1, 3 entries queued, rnd_req=1 for 5 clks with rnd_addr=0x2A → tbl_addr=0x2A, rnd_gnt=1, tbl_we=0 throughout. Drain resumes the cycle rnd_req drops.
5. vblank=0, 4 entries queued, write addr7=0x01 → 4 writes on consecutive clks. flush_done pulses once, the cycle after count hits 0, and the state reads NORMAL afterwards.
6. 5 entries queued, assert reset=0 for one clk mid-drain → no tbl_we afterwards, fifo_empty=1, overflow=0, hps_readdata=0.

Source files
------------

// File: rtl/sprite_cmd_scheduler.sv
// Queues HPS-staged 48-bit sprite descriptors and drains them into the shared
// descriptor table during blanking (or on flush), yielding the port to the renderer.
module sprite_cmd_scheduler #(
    parameter int DEPTH       = 8,
    parameter int IDX_W       = 8,
    parameter int VBLANK_GATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       hps_writedata,
    input  logic [2:0]       hps_address,
    input  logic             hps_write,
    input  logic             hps_read,
    input  logic             hps_chipselect,
    output logic [7:0]       hps_readdata,
    input  logic             vblank,
    input  logic             rnd_req,
    input  logic [IDX_W-1:0] rnd_addr,
    output logic             rnd_gnt,
    output logic [IDX_W-1:0] tbl_addr,
    output logic             tbl_we,
    output logic [47:0]      tbl_wdata,
    output logic             flush_done
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {NORMAL, FLUSH} state_t;

    state_t             state;
    logic [5:0][7:0]    staging;
    logic [IDX_W-1:0]   idx_mem  [DEPTH];
    logic [47:0]        data_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               overflow;

    logic               bus_wr;
    logic               stage_wr;
    logic               commit;
    logic               ctrl_wr;
    logic               empty;
    logic               full;
    logic               win;
    logic               pop;
    logic               push;
    logic               drop;
    logic               flush_req;
    logic               ovf_clr;
    logic [IDX_W-1:0]   head_idx;
    logic [47:0]        head_data;

    assign bus_wr    = hps_chipselect & hps_write;
    assign stage_wr  = bus_wr && (hps_address < 3'd6);
    assign commit    = bus_wr && (hps_address == 3'd6);
    assign ctrl_wr   = bus_wr && (hps_address == 3'd7);
    assign flush_req = ctrl_wr & hps_writedata[0];
    assign ovf_clr   = ctrl_wr & hps_writedata[1];

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign win   = (VBLANK_GATE == 0) || vblank || (state == FLUSH);

    // Gating with reset keeps a held reset from leaking a table write out of a stale queue.
    assign pop  = reset & ~rnd_req & win & ~empty;
    assign push = commit & (~full | pop);
    assign drop = commit & ~push;

    // Masking the head while empty keeps the table outputs defined before any entry is written.
    assign head_idx  = empty ? '0 : idx_mem[rd_ptr];
    assign head_data = empty ? '0 : data_mem[rd_ptr];

    assign rnd_gnt   = rnd_req;
    assign tbl_we    = pop;
    assign tbl_addr  = rnd_req ? rnd_addr : head_idx;
    assign tbl_wdata = head_data;

    // Queue storage carries data only; occupancy is tracked by the control registers.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr]  <= hps_writedata[IDX_W-1:0];
            data_mem[wr_ptr] <= staging;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            staging      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            hps_readdata <= 8'h00;
            flush_done   <= 1'b0;
            state        <= NORMAL;
        end else begin
            if (stage_wr)
                staging[hps_address] <= hps_writedata;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;

            if (hps_chipselect && hps_read)
                hps_readdata <= {4'b0000, state == FLUSH, overflow, empty, full};

            flush_done <= 1'b0;
            case (state)
                NORMAL: begin
                    if (flush_req)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // A commit landing on an empty queue keeps the flush open.
                    if (empty && !push) begin
                        state      <= NORMAL;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Directed bench for sprite_cmd_scheduler: staging/commit, blanking gate, overflow,
// renderer pre-emption, flush and mid-drain reset.
module tb_sprite_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hps_writedata;
    logic [2:0]  hps_address;
    logic        hps_write;
    logic        hps_read;
    logic        hps_chipselect;
    logic [7:0]  hps_readdata;
    logic        vblank;
    logic        rnd_req;
    logic [7:0]  rnd_addr;
    logic        rnd_gnt;
    logic [7:0]  tbl_addr;
    logic        tbl_we;
    logic [47:0] tbl_wdata;
    logic        flush_done;

    sprite_cmd_scheduler #(.DEPTH(8), .IDX_W(8), .VBLANK_GATE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .hps_writedata  (hps_writedata),
        .hps_address    (hps_address),
        .hps_write      (hps_write),
        .hps_read       (hps_read),
        .hps_chipselect (hps_chipselect),
        .hps_readdata   (hps_readdata),
        .vblank         (vblank),
        .rnd_req        (rnd_req),
        .rnd_addr       (rnd_addr),
        .rnd_gnt        (rnd_gnt),
        .tbl_addr       (tbl_addr),
        .tbl_we         (tbl_we),
        .tbl_wdata      (tbl_wdata),
        .flush_done     (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [47:0] d;
        int          c;
    } wr_t;

    wr_t log_q[$];
    int  done_q[$];
    int  cyc_n = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Table writes and flush pulses are logged mid-cycle for later checking.
    always @(negedge clk) begin
        wr_t e;
        if (tbl_we === 1'b1) begin
            e.a = tbl_addr;
            e.d = tbl_wdata;
            e.c = cyc_n;
            log_q.push_back(e);
        end
        if (flush_done === 1'b1)
            done_q.push_back(cyc_n);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        hps_address    = a;
        hps_writedata  = d;
        hps_chipselect = 1'b1;
        hps_write      = 1'b1;
        cyc();
        hps_chipselect = 1'b0;
        hps_write      = 1'b0;
    endtask

    task automatic bus_rd(output logic [7:0] v);
        hps_chipselect = 1'b1;
        hps_read       = 1'b1;
        cyc();
        hps_chipselect = 1'b0;
        hps_read       = 1'b0;
        v = hps_readdata;
    endtask

    initial begin
        logic [7:0] st;
        int         c9;
        int         w;

        reset = 1'b0; hps_writedata = 8'h00; hps_address = 3'd0; hps_write = 1'b0;
        hps_read = 1'b0; hps_chipselect = 1'b0; vblank = 1'b1; rnd_req = 1'b0; rnd_addr = 8'h00;
        repeat (3) cyc();
        #1;
        chk("rst_tbl_we", 64'(tbl_we), 64'd0);
        chk("rst_readdata", 64'(hps_readdata), 64'h00);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        reset = 1'b1;
        cyc();

        // 1: descriptor held back until vblank
        vblank = 1'b0;
        bus_wr(3'd0, 8'hFD); bus_wr(3'd1, 8'hFF); bus_wr(3'd2, 8'hFF);
        bus_wr(3'd3, 8'hFF); bus_wr(3'd4, 8'h00); bus_wr(3'd5, 8'h00);
        bus_wr(3'd6, 8'h05);
        repeat (20) cyc();
        chk("t1_no_write_before_vblank", 64'(log_q.size()), 64'd0);
        vblank = 1'b1;
        cyc();
        chk("t1_one_write", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) begin
            chk("t1_addr", 64'(log_q[0].a), 64'h05);
            chk("t1_data", 64'(log_q[0].d), 64'h0000_FFFF_FFFD);
        end
        repeat (3) cyc();
        chk("t1_single_pulse", 64'(log_q.size()), 64'd1);
        log_q.delete();

        // 2: fill to DEPTH behind the renderer, then a 9th commit alongside the first pop
        rnd_req = 1'b1;
        for (int i = 0; i < 8; i++) bus_wr(3'd6, 8'(i));
        chk("t2_held_by_renderer", 64'(log_q.size()), 64'd0);
        rnd_req = 1'b0;
        c9 = cyc_n;
        bus_wr(3'd6, 8'h08);
        repeat (12) cyc();
        chk("t2_nine_writes", 64'(log_q.size()), 64'd9);
        if (log_q.size() == 9) begin
            chk("t2_first_pop_cycle", 64'(log_q[0].c), 64'(c9));
            for (int i = 0; i < 9; i++) chk($sformatf("t2_order_%0d", i), 64'(log_q[i].a), 64'(i));
        end
        bus_rd(st);
        chk("t2_status", 64'(st), 64'h02);
        log_q.delete();

        // 3: overflow on the 9th commit with no draining, then clear
        vblank = 1'b0;
        for (int i = 0; i < 9; i++) bus_wr(3'd6, 8'(8'h10 + i));
        bus_rd(st);
        chk("t3_status_ovf_full", 64'(st), 64'h05);
        bus_wr(3'd7, 8'h02);
        bus_rd(st);
        chk("t3_status_ovf_cleared", 64'(st), 64'h01);
        vblank = 1'b1;
        repeat (10) cyc();
        chk("t3_eight_writes", 64'(log_q.size()), 64'd8);
        if (log_q.size() == 8) chk("t3_last_idx", 64'(log_q[7].a), 64'h17);
        log_q.delete();

        // 4: renderer pre-emption
        vblank = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(3'd6, 8'(8'h20 + i));
        rnd_req = 1'b1; rnd_addr = 8'h2A; vblank = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t4_addr_%0d", k), 64'(tbl_addr), 64'h2A);
            chk($sformatf("t4_gnt_%0d", k), 64'(rnd_gnt), 64'd1);
            chk($sformatf("t4_we_%0d", k), 64'(tbl_we), 64'd0);
            cyc();
        end
        rnd_req = 1'b0;
        #1;
        chk("t4_resume_we", 64'(tbl_we), 64'd1);
        chk("t4_resume_addr", 64'(tbl_addr), 64'h20);
        repeat (4) cyc();
        chk("t4_three_writes", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) chk("t4_last_idx", 64'(log_q[2].a), 64'h22);
        log_q.delete();

        // 5: flush outside vblank, with per-commit staging byte 0 updates
        vblank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_wr(3'd0, 8'(8'h30 + i));
            bus_wr(3'd6, 8'(8'h30 + i));
        end
        w = cyc_n;
        bus_wr(3'd7, 8'h01);
        repeat (8) cyc();
        chk("t5_four_writes", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t5_cycle_%0d", i), 64'(log_q[i].c), 64'(w + 1 + i));
                chk($sformatf("t5_data_%0d", i), 64'(log_q[i].d), 64'h0000_FFFF_FF30 + 64'(i));
            end
        end
        chk("t5_done_count", 64'(done_q.size()), 64'd1);
        if (done_q.size() == 1) chk("t5_done_cycle", 64'(done_q[0]), 64'(w + 6));
        bus_rd(st);
        chk("t5_status_normal", 64'(st), 64'h02);
        log_q.delete(); done_q.delete();

        // 5b: flush on an empty queue still pulses once
        w = cyc_n;
        bus_wr(3'd7, 8'h01);
        repeat (4) cyc();
        chk("t5b_done_count", 64'(done_q.size()), 64'd1);
        if (done_q.size() == 1) chk("t5b_done_cycle", 64'(done_q[0]), 64'(w + 2));
        done_q.delete();

        // 6: reset mid-drain with overflow set
        for (int i = 0; i < 9; i++) bus_wr(3'd6, 8'(8'h40 + i));
        vblank = 1'b1;
        cyc(); cyc();
        chk("t6_pre_reset_writes", 64'(log_q.size()), 64'd2);
        reset = 1'b0;
        #1;
        chk("t6_we_in_reset", 64'(tbl_we), 64'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("t6_readdata_zero", 64'(hps_readdata), 64'h00);
        chk("t6_we_after_reset", 64'(tbl_we), 64'd0);
        repeat (10) cyc();
        chk("t6_no_more_writes", 64'(log_q.size()), 64'd2);
        bus_rd(st);
        chk("t6_status_empty", 64'(st), 64'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
